multicycle_controller: RTL

Control unit for the multicycle RV32I processor: a Moore state machine plus ALU decode and branch-condition logic that sequences a shared-memory datapath (single memory for fetch and data, instruction register, OldPC, A/B, ALUOut and Data registers) through fetch, decode, execute, memory and writeback cycles. It sits alongside the datapath inside the multicycle core. It replaces the single-cycle combinational main decoder. ALU encodings, immediate-source encodings and branch semantics are unchanged from the single-cycle core.

---
 rtl/multicycle_pkg.sv | 82 ++++++++
 rtl/aludec.sv | 38 +++
 rtl/mainfsm.sv | 121 ++++++++++++
 rtl/multicycle_controller.sv | 82 ++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// Holds the FSM state enum, opcodes, datapath mux selects, ALU codes
// (also used by the ALU) and the control bundle driven by the main FSM.
package multicycle_pkg;

  localparam int unsigned OP_W     = 7;
  localparam int unsigned F3_W     = 3;
  localparam int unsigned ALUOP_W  = 2;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned IMM_W    = 3;
  localparam int unsigned ALUCTL_W = 4;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, LUI, AUIPC, JAL, ALUWB, BRANCH
  } state_t;

  // Opcodes
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;

  // ALUOp
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  // ALUSrcA
  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_A     = 2'b10;
  localparam logic [SEL_W-1:0] SRCA_ZERO  = 2'b11;

  // ALUSrcB
  localparam logic [SEL_W-1:0] SRCB_REG  = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

  // ResultSrc
  localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
  localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

  // ImmSrc
  localparam logic [IMM_W-1:0] IMM_I = 3'b000;
  localparam logic [IMM_W-1:0] IMM_S = 3'b001;
  localparam logic [IMM_W-1:0] IMM_B = 3'b010;
  localparam logic [IMM_W-1:0] IMM_J = 3'b011;
  localparam logic [IMM_W-1:0] IMM_U = 3'b100;

  // ALUControl
  localparam logic [ALUCTL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALUCTL_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALUCTL_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [ALUCTL_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [ALUCTL_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALUCTL_W-1:0] ALU_SLT  = 4'b0101;
  localparam logic [ALUCTL_W-1:0] ALU_SLL  = 4'b0110;
  localparam logic [ALUCTL_W-1:0] ALU_SRA  = 4'b0111;
  localparam logic [ALUCTL_W-1:0] ALU_SRL  = 4'b1000;
  localparam logic [ALUCTL_W-1:0] ALU_SLTU = 4'b1001;

  // Per-state control bundle produced by the main FSM
  typedef struct packed {
    logic              pc_update;
    logic              branch;
    logic              adr_src;
    logic              mem_write;
    logic              ir_write;
    logic              reg_write;
    logic [SEL_W-1:0]  result_src;
    logic [SEL_W-1:0]  alu_src_a;
    logic [SEL_W-1:0]  alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
  } fsm_ctl_t;

endpackage

// File: rtl/aludec.sv
// ALU decoder shared with the single-cycle core.
// Ports: opb5 (op[5]), funct3, funct7b5, ALUOp in; ALUControl out.
module aludec
  import multicycle_pkg::*;
(
  input  logic                opb5,
  input  logic [F3_W-1:0]     funct3,
  input  logic                funct7b5,
  input  logic [ALUOP_W-1:0]  ALUOp,
  output logic [ALUCTL_W-1:0] ALUControl
);

  logic rtype_sub;

  // Only R-type (op[5]=1) with funct7b5 subtracts; addi ignores funct7b5
  assign rtype_sub = opb5 & funct7b5;

  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  ALUControl = rtype_sub ? ALU_SUB : ALU_ADD;
          3'b001:  ALUControl = ALU_SLL;
          3'b010:  ALUControl = ALU_SLT;
          3'b011:  ALUControl = ALU_SLTU;
          3'b100:  ALUControl = ALU_XOR;
          3'b101:  ALUControl = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  ALUControl = ALU_OR;
          default: ALUControl = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mainfsm.sv
// Main sequencing FSM of the multicycle core (Moore).
// Ports: clk, reset (sync, active-low), op in; ctl (per-state control bundle) out.
// While reset is low the FETCH decode is shown with all write enables cleared.
module mainfsm
  import multicycle_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] op,
  output fsm_ctl_t        ctl
);

  state_t state_q, state_d, dec_state;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next state and per-state control decode
  always_comb begin
    state_d   = FETCH;
    dec_state = reset ? state_q : FETCH;
    ctl       = '0;

    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECR;
          OP_ITYPE:          state_d = EXECI;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          OP_LUI:            state_d = LUI;
          OP_AUIPC:          state_d = AUIPC;
          default:           state_d = FETCH;  // illegal op is skipped
        endcase
      end
      MEMADR:  state_d = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD: state_d = MEMWB;
      EXECR, EXECI, LUI, AUIPC, JAL: state_d = ALUWB;
      default: state_d = FETCH;
    endcase

    case (dec_state)
      FETCH: begin
        ctl.ir_write   = 1'b1;
        ctl.alu_src_a  = SRCA_PC;
        ctl.alu_src_b  = SRCB_FOUR;
        ctl.alu_op     = ALUOP_ADD;
        ctl.result_src = RES_ALURESULT;
        ctl.pc_update  = 1'b1;
      end
      DECODE: begin
        ctl.alu_src_a = SRCA_OLDPC;
        ctl.alu_src_b = SRCB_IMM;
      end
      MEMADR, EXECI: begin
        ctl.alu_src_a = SRCA_A;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = (dec_state == EXECI) ? ALUOP_FUNCT : ALUOP_ADD;
      end
      MEMREAD: begin
        ctl.result_src = RES_ALUOUT;
        ctl.adr_src    = 1'b1;
      end
      MEMWB: begin
        ctl.result_src = RES_DATA;
        ctl.reg_write  = 1'b1;
      end
      MEMWRITE: begin
        ctl.result_src = RES_ALUOUT;
        ctl.adr_src    = 1'b1;
        ctl.mem_write  = 1'b1;
      end
      EXECR: begin
        ctl.alu_src_a = SRCA_A;
        ctl.alu_src_b = SRCB_REG;
        ctl.alu_op    = ALUOP_FUNCT;
      end
      LUI: begin
        ctl.alu_src_a = SRCA_ZERO;
        ctl.alu_src_b = SRCB_IMM;
      end
      AUIPC: begin
        ctl.alu_src_a = SRCA_OLDPC;
        ctl.alu_src_b = SRCB_IMM;
      end
      JAL: begin
        ctl.alu_src_a  = SRCA_OLDPC;
        ctl.alu_src_b  = SRCB_FOUR;
        ctl.result_src = RES_ALUOUT;
        ctl.pc_update  = 1'b1;
      end
      ALUWB: begin
        ctl.result_src = RES_ALUOUT;
        ctl.reg_write  = 1'b1;
      end
      BRANCH: begin
        ctl.alu_src_a  = SRCA_A;
        ctl.alu_src_b  = SRCB_REG;
        ctl.alu_op     = ALUOP_SUB;
        ctl.result_src = RES_ALUOUT;
        ctl.branch     = 1'b1;
      end
      default: ctl = '0;
    endcase

    // Reset blocks every architectural write
    if (!reset) begin
      ctl.pc_update = 1'b0;
      ctl.branch    = 1'b0;
      ctl.mem_write = 1'b0;
      ctl.ir_write  = 1'b0;
      ctl.reg_write = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control unit of the multicycle RV32I core.
// Ports: clk, reset (sync, active-low), op/funct3/funct7b5 from the IR,
// ALU flags Zero/V/N/C in; datapath enables, mux selects, ImmSrc and
// ALUControl out. All outputs are combinational.
module multicycle_controller
  import multicycle_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [OP_W-1:0]     op,
  input  logic [F3_W-1:0]     funct3,
  input  logic                funct7b5,
  input  logic                Zero,
  input  logic                V,
  input  logic                N,
  input  logic                C,
  output logic                PCWrite,
  output logic                AdrSrc,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                RegWrite,
  output logic [SEL_W-1:0]    ResultSrc,
  output logic [SEL_W-1:0]    ALUSrcA,
  output logic [SEL_W-1:0]    ALUSrcB,
  output logic [IMM_W-1:0]    ImmSrc,
  output logic [ALUCTL_W-1:0] ALUControl
);

  fsm_ctl_t ctl;
  logic     cond;

  mainfsm u_mainfsm (
    .clk   (clk),
    .reset (reset),
    .op    (op),
    .ctl   (ctl)
  );

  aludec u_aludec (
    .opb5       (op[5]),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .ALUOp      (ctl.alu_op),
    .ALUControl (ALUControl)
  );

  // Immediate format depends only on the opcode
  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_STORE:          ImmSrc = IMM_S;
      OP_BRANCH:         ImmSrc = IMM_B;
      OP_JAL:            ImmSrc = IMM_J;
      OP_LUI, OP_AUIPC:  ImmSrc = IMM_U;
      default:           ImmSrc = IMM_I;
    endcase
  end

  // Branch condition from the flags of the rs1 - rs2 subtraction
  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000:  cond = Zero;
      3'b001:  cond = ~Zero;
      3'b100:  cond = N ^ V;
      3'b101:  cond = ~(N ^ V);
      3'b110:  cond = ~C;
      3'b111:  cond = C;
      default: cond = 1'b0;
    endcase
  end

  assign PCWrite   = ctl.pc_update | (ctl.branch & cond);
  assign AdrSrc    = ctl.adr_src;
  assign MemWrite  = ctl.mem_write;
  assign IRWrite   = ctl.ir_write;
  assign RegWrite  = ctl.reg_write;
  assign ResultSrc = ctl.result_src;
  assign ALUSrcA   = ctl.alu_src_a;
  assign ALUSrcB   = ctl.alu_src_b;

endmodule
